// File: rtl/block_checker_pkg.sv
// Shared definitions for the begin/end nesting checker.
// Contents:
//   word_state_e : word-recognition FSM states
//   CH_*         : ASCII constants used by the recogniser
//   to_lower()   : folds 'A'-'Z' onto 'a'-'z', leaves everything else alone
package block_checker_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B,
    ST_BE,
    ST_BEG,
    ST_BEGI,
    ST_BEGIN,
    ST_E,
    ST_EN,
    ST_END,
    ST_OTHER
  } word_state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;
  localparam logic [7:0] CH_D     = 8'h64;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5a) return c + 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/bc_word_classifier.sv
// Word recogniser for the nesting checker: tracks how much of "begin" or
// "end" the current word matches and strobes a commit when a space closes
// a complete keyword.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   in_valid     : in_char is consumed at this rising edge
//   in_char      : ASCII character
//   state        : registered word state
//   commit_begin : space arriving while the word is exactly "begin"
//   commit_end   : space arriving while the word is exactly "end"
module bc_word_classifier
  import block_checker_pkg::*;
#(
  parameter bit CASE_SENS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output word_state_e state,
  output logic        commit_begin,
  output logic        commit_end
);

  word_state_e state_q;
  word_state_e state_d;
  logic [7:0]  ch;

  // Case-insensitive matching folds upper case before any comparison;
  // the space delimiter is unaffected by the fold.
  assign ch = CASE_SENS ? in_char : to_lower(in_char);

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      if (ch == CH_SPACE) begin
        state_d = ST_IDLE;
      end else begin
        // Any character that breaks the keyword prefix lands in OTHER.
        state_d = ST_OTHER;
        case (state_q)
          ST_IDLE: begin
            if (ch == CH_B)      state_d = ST_B;
            else if (ch == CH_E) state_d = ST_E;
          end
          ST_B:    if (ch == CH_E) state_d = ST_BE;
          ST_BE:   if (ch == CH_G) state_d = ST_BEG;
          ST_BEG:  if (ch == CH_I) state_d = ST_BEGI;
          ST_BEGI: if (ch == CH_N) state_d = ST_BEGIN;
          ST_E:    if (ch == CH_N) state_d = ST_EN;
          ST_EN:   if (ch == CH_D) state_d = ST_END;
          default: state_d = ST_OTHER;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign state        = state_q;
  assign commit_begin = in_valid && (ch == CH_SPACE) && (state_q == ST_BEGIN);
  assign commit_end   = in_valid && (ch == CH_SPACE) && (state_q == ST_END);

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker over an ASCII character stream.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : in is consumed at this rising edge
//   in         : ASCII character
//   result     : 1 when the stream so far, with the current word treated as
//                complete, is balanced and no error has been seen
//   depth      : committed nesting depth
//   error      : sticky unmatched-end / depth-overflow flag
module block_nest_checker
  import block_checker_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 16,
  parameter bit          CASE_SENS = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  word_state_e        state;
  logic               commit_begin;
  logic               commit_end;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               error_q, error_d;

  bc_word_classifier #(
    .CASE_SENS (CASE_SENS)
  ) u_classifier (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_char      (in),
    .state        (state),
    .commit_begin (commit_begin),
    .commit_end   (commit_end)
  );

  // After an error the depth is frozen; the word FSM keeps running but its
  // commits no longer matter.
  always_comb begin
    depth_d = depth_q;
    error_d = error_q;
    if (!error_q) begin
      if (commit_begin) begin
        if (depth_q == DEPTH_MAX) error_d = 1'b1;
        else                      depth_d = depth_q + DEPTH_ONE;
      end else if (commit_end) begin
        if (depth_q == '0) error_d = 1'b1;
        else               depth_d = depth_q - DEPTH_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      error_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      error_q <= error_d;
    end
  end

  // Result treats the word in progress as if a space followed it: a pending
  // "begin" can never balance, a pending "end" balances only from depth 1.
  always_comb begin
    result = 1'b0;
    if (!error_q) begin
      case (state)
        ST_BEGIN: result = 1'b0;
        ST_END:   result = (depth_q == DEPTH_ONE);
        default:  result = (depth_q == '0);
      endcase
    end
  end

  assign depth = depth_q;
  assign error = error_q;

endmodule

// File: tb/tb_block_nest_checker.sv
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h00;

  logic        r0, r1, r2;
  logic [15:0] d0;
  logic [1:0]  d1;
  logic [15:0] d2;
  logic        e0, e1, e2;

  always #5 clk = ~clk;

  block_nest_checker dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(r0), .depth(d0), .error(e0));

  block_nest_checker #(.DEPTH_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(r1), .depth(d1), .error(e1));

  block_nest_checker #(.CASE_SENS(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(r2), .depth(d2), .error(e2));

  // Which instance the scoreboard is watching.
  int sel = 0;
  logic        obs_r;
  logic [15:0] obs_d;
  logic        obs_e;

  always_comb begin
    obs_r = r0; obs_d = d0; obs_e = e0;
    case (sel)
      1: begin obs_r = r1; obs_d = {14'd0, d1}; obs_e = e1; end
      2: begin obs_r = r2; obs_d = d2; obs_e = e2; end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: keeps the current word as text and commits it on space.
  string m_word;
  int    m_depth;
  bit    m_err;
  int    m_max;
  bit    m_cs;

  typedef struct {
    logic  r;
    int    d;
    logic  e;
    string tag;
  } exp_t;
  exp_t sb[$];

  function automatic void model_reset(int max_depth, bit cs);
    m_word = ""; m_depth = 0; m_err = 1'b0; m_max = max_depth; m_cs = cs;
  endfunction

  function automatic void model_char(byte c);
    byte f;
    if (c == 8'h20) begin
      if (!m_err && m_word == "begin") begin
        if (m_depth == m_max) m_err = 1'b1;
        else m_depth++;
      end else if (!m_err && m_word == "end") begin
        if (m_depth == 0) m_err = 1'b1;
        else m_depth--;
      end
      m_word = "";
    end else begin
      f = c;
      if (!m_cs && c >= 8'h41 && c <= 8'h5a) f = c + 8'd32;
      m_word = $sformatf("%s%c", m_word, f);
    end
  endfunction

  function automatic logic model_result();
    if (m_err) return 1'b0;
    if (m_word == "begin") return 1'b0;
    if (m_word == "end") return (m_depth == 1);
    return (m_depth == 0);
  endfunction

  // One clock of stimulus: expectation queued at drive time, compared
  // #1 after the rising edge.
  task automatic step(input bit v, input byte c, input string tag);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_ch = c;
    if (v) model_char(c);
    e.r = model_result(); e.d = m_depth; e.e = m_err; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s scoreboard: queue empty", tag);
    end else begin
      e = sb.pop_front();
      if (obs_r !== e.r) begin
        n_errors++;
        $display("FAIL %s result: got %0b expected %0b", e.tag, obs_r, e.r);
      end
      n_checks++;
      if (obs_d !== 16'(e.d)) begin
        n_errors++;
        $display("FAIL %s depth: got %0d expected %0d", e.tag, obs_d, e.d);
      end
      n_checks++;
      if (obs_e !== e.e) begin
        n_errors++;
        $display("FAIL %s error: got %0b expected %0b", e.tag, obs_e, e.e);
      end
    end
  endtask

  task automatic feed(input string name, input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], $sformatf("%s#%0d", name, i));
  endtask

  task automatic do_reset(input int which, input int max_depth, input bit cs);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sel = which;
    model_reset(max_depth, cs);
  endtask

  task automatic test_reset();
    do_reset(0, 65535, 1'b0);
    #1;
    n_checks++;
    if (r0 !== 1'b1 || r1 !== 1'b1 || r2 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_result: got %0b%0b%0b expected 111", r0, r1, r2);
    end
    n_checks++;
    if (d0 !== 16'd0 || d1 !== 2'd0 || d2 !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_depth: got %0d/%0d/%0d expected 0", d0, d1, d2);
    end
    n_checks++;
    if (e0 !== 1'b0 || e1 !== 1'b0 || e2 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_error: got %0b%0b%0b expected 000", e0, e1, e2);
    end
  endtask

  task automatic test_nesting();
    do_reset(0, 65535, 1'b0);
    feed("nest", "a begin begin end End");
    n_checks++;
    if (d0 !== 16'd1 || r0 !== 1'b1) begin
      n_errors++;
      $display("FAIL nest_final_d: got depth %0d result %0b expected 1 1", d0, r0);
    end
    step(1'b1, 8'h20, "nest_sp");
    n_checks++;
    if (d0 !== 16'd0 || r0 !== 1'b1 || e0 !== 1'b0) begin
      n_errors++;
      $display("FAIL nest_close: got d=%0d r=%0b e=%0b expected 0 1 0", d0, r0, e0);
    end
  endtask

  task automatic test_underflow();
    do_reset(0, 65535, 1'b0);
    feed("under", "end");
    n_checks++;
    if (r0 !== 1'b0 || e0 !== 1'b0) begin
      n_errors++;
      $display("FAIL under_tentative: got r=%0b e=%0b expected 0 0", r0, e0);
    end
    feed("under2", " begin end ");
    n_checks++;
    if (e0 !== 1'b1 || r0 !== 1'b0 || d0 !== 16'd0) begin
      n_errors++;
      $display("FAIL under_sticky: got e=%0b r=%0b d=%0d expected 1 0 0", e0, r0, d0);
    end
  endtask

  task automatic test_non_keyword();
    do_reset(0, 65535, 1'b0);
    feed("nkw", "beginx ");
    feed("nkw_punct", "end; ");
    feed("mixcase", "BeGiN ");
    n_checks++;
    if (d0 !== 16'd1) begin
      n_errors++;
      $display("FAIL mixcase_depth: got %0d expected 1", d0);
    end
  endtask

  task automatic test_overflow();
    do_reset(1, 3, 1'b0);
    feed("ovf", "begin begin begin ");
    n_checks++;
    if (d1 !== 2'd3 || e1 !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_full: got d=%0d e=%0b expected 3 0", d1, e1);
    end
    feed("ovf4", "begin ");
    n_checks++;
    if (e1 !== 1'b1 || d1 !== 2'd3 || r1 !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_err: got e=%0b d=%0d r=%0b expected 1 3 0", e1, d1, r1);
    end
    feed("ovf_after", "end end ");
  endtask

  task automatic test_hold_and_async_reset();
    do_reset(0, 65535, 1'b0);
    feed("hold_pre", "begin beg");
    for (int i = 0; i < 5; i++)
      step(1'b0, byte'($urandom_range(255, 0)), $sformatf("hold_idle%0d", i));
    feed("hold_post", "in");
    n_checks++;
    if (r0 !== 1'b0 || d0 !== 16'd1) begin
      n_errors++;
      $display("FAIL hold_resume: got r=%0b d=%0d expected 0 1", r0, d0);
    end
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (r0 !== 1'b1 || d0 !== 16'd0 || e0 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got r=%0b d=%0d e=%0b expected 1 0 0", r0, d0, e0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset(65535, 1'b0);
  endtask

  task automatic test_case_sensitive();
    do_reset(2, 65535, 1'b1);
    feed("cs", "BEGIN END begin ");
    n_checks++;
    if (d2 !== 16'd1 || e2 !== 1'b0) begin
      n_errors++;
      $display("FAIL cs_final: got d=%0d e=%0b expected 1 0", d2, e2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(0, 65535, 1'b0);
    feed("b2b", "begin  begin x end end ");
    step(1'b0, 8'h65, "b2b_idle");
    feed("b2b_tail", "beginbegin end ");
  endtask

  initial begin
    test_reset();
    test_nesting();
    test_underflow();
    test_non_keyword();
    test_overflow();
    test_hold_and_async_reset();
    test_case_sensitive();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
